inst_mem_pipe: RTL and testbench

Parametrised, byte-addressed instruction memory for the pipelined core's fetch stage. It returns little-endian INSN_W-bit instructions through a registered read with a valid/ready handshake, backpressure, and branch flush. A sequential byte-load port fills the array at run time, so contents are no longer hard-wired at reset.

---
 rtl/inst_mem_pipe.sv | 111 +++++++++++
 tb/tb_inst_mem_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_pipe.sv
// Byte-addressed instruction memory with a registered, one-deep fetch response,
// branch flush and a sequential byte-load port.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_RUN  | fetches accepted; prog_we ignored
// ST_LOAD | fetch blocked, bytes written at prog_count, response dropped
module inst_mem_pipe #(
  parameter int ADDR_W = 8,
  parameter int INSN_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  input  logic              flush,
  output logic              resp_valid,
  output logic [INSN_W-1:0] resp_insn,
  output logic              resp_misalign,
  input  logic              resp_ready,
  input  logic              prog_start,
  input  logic              prog_we,
  input  logic [7:0]        prog_data,
  input  logic              prog_done,
  output logic              prog_busy,
  output logic [ADDR_W-1:0] prog_count
);

  localparam int NB    = INSN_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  // Low address bits that select a byte inside one instruction.
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(NB - 1);

  typedef enum logic {ST_RUN, ST_LOAD} state_t;

  state_t            state, state_nxt;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] cnt_nxt;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] base;
  logic [INSN_W-1:0] rd_insn;
  logic              accept;
  logic              wr_en;
  logic              last_byte;

  assign prog_busy   = (state == ST_LOAD);
  assign fetch_ready = (state == ST_RUN) && (!resp_valid || resp_ready);
  assign accept      = fetch_valid && fetch_ready;
  // A start pulse opens the load window immediately, so a write in that
  // same cycle lands at address 0.
  assign wr_en       = prog_we && (prog_start || state == ST_LOAD);
  assign wr_addr     = prog_start ? '0 : prog_count;
  assign last_byte   = (state == ST_LOAD) && !prog_start && prog_we && (prog_count == '1);
  assign base        = fetch_addr & ~LOW_MASK;

  // Assemble the little-endian instruction from the aligned base.
  always_comb begin
    rd_insn = '0;
    for (int i = 0; i < NB; i++) begin
      rd_insn[8*i +: 8] = mem[base + ADDR_W'(i)];
    end
  end

  // Next-state and load-counter logic; start has priority over done.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = prog_count;
    if (prog_start) begin
      state_nxt = ST_LOAD;
      cnt_nxt   = prog_we ? ADDR_W'(1) : '0;
    end else if (state == ST_LOAD) begin
      if (prog_we) cnt_nxt = prog_count + ADDR_W'(1);
      if (prog_done || last_byte) state_nxt = ST_RUN;
    end
  end

  // State and load-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_RUN;
      prog_count <= '0;
    end else begin
      state      <= state_nxt;
      prog_count <= cnt_nxt;
    end
  end

  // One-deep response register; a new accept overrides a flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid    <= 1'b0;
      resp_insn     <= '0;
      resp_misalign <= 1'b0;
    end else if (state == ST_LOAD || prog_start) begin
      resp_valid <= 1'b0;
    end else if (accept) begin
      resp_valid    <= 1'b1;
      resp_insn     <= rd_insn;
      resp_misalign <= |(fetch_addr & LOW_MASK);
    end else if (flush || resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  // Byte array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= prog_data;
  end

endmodule

// File: tb/tb_inst_mem_pipe.sv
// Bench for inst_mem_pipe: cycle model for the 8-bit-address instance plus
// directed literal checks, and a 4-bit-address instance for counter wrap.
module tb_inst_mem_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fv = 1'b0, fl = 1'b0, rr = 1'b1, ps = 1'b0, pw = 1'b0, pdn = 1'b0;
  logic [7:0]  fa = '0, pd = '0, pc;
  logic        fr, rv, rm, pb;
  logic [15:0] ri;

  logic        f4v = 1'b0, f4fl = 1'b0, r4r = 1'b1, p4s = 1'b0, p4w = 1'b0, p4dn = 1'b0;
  logic [3:0]  f4a = '0, p4c;
  logic [7:0]  p4d = '0;
  logic        f4r, r4v, r4m, p4b;
  logic [15:0] r4i;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  inst_mem_pipe #(.ADDR_W(8), .INSN_W(16)) u8 (
    .clk(clk), .rst(rst), .fetch_valid(fv), .fetch_addr(fa), .fetch_ready(fr),
    .flush(fl), .resp_valid(rv), .resp_insn(ri), .resp_misalign(rm), .resp_ready(rr),
    .prog_start(ps), .prog_we(pw), .prog_data(pd), .prog_done(pdn),
    .prog_busy(pb), .prog_count(pc));

  inst_mem_pipe #(.ADDR_W(4), .INSN_W(16)) u4 (
    .clk(clk), .rst(rst), .fetch_valid(f4v), .fetch_addr(f4a), .fetch_ready(f4r),
    .flush(f4fl), .resp_valid(r4v), .resp_insn(r4i), .resp_misalign(r4m), .resp_ready(r4r),
    .prog_start(p4s), .prog_we(p4w), .prog_data(p4d), .prog_done(p4dn),
    .prog_busy(p4b), .prog_count(p4c));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the 8-bit instance: memory image, load window,
  // and the single pending response.
  int         m_mem [256];
  bit         m_load = 0;
  int         m_cnt = 0;
  bit         m_have = 0;
  int         m_insn = 0;
  bit         m_mis = 0;

  function automatic int model_read(input int a);
    int b;
    b = (a / 2) * 2;
    return m_mem[(b + 1) % 256] * 256 + m_mem[b];
  endfunction

  initial for (int i = 0; i < 256; i++) m_mem[i] = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_load = 0; m_cnt = 0; m_have = 0; m_insn = 0; m_mis = 0;
    end else if (ps) begin
      m_load = 1;
      m_have = 0;
      if (pw) begin m_mem[0] = pd; m_cnt = 1; end
      else m_cnt = 0;
    end else if (m_load) begin
      m_have = 0;
      if (pw) begin
        m_mem[m_cnt] = pd;
        m_cnt = (m_cnt + 1) % 256;
        if (m_cnt == 0) m_load = 0;
      end
      if (pdn) m_load = 0;
    end else begin
      if (fv && (!m_have || rr)) begin
        m_have = 1;
        m_insn = model_read(fa);
        m_mis  = (fa % 2) != 0;
      end else if (fl || rr) begin
        m_have = 0;
      end
    end
  end

  // Per-cycle comparison, sampled mid-low-phase after inputs settle.
  always begin
    @(negedge clk);
    #3;
    chk("resp_valid", rv, m_have);
    chk("fetch_ready", fr, (!m_load && (!m_have || rr)));
    chk("prog_busy", pb, m_load);
    chk("prog_count", pc, m_cnt);
    chk("resp_insn", ri, m_insn);
    chk("resp_misalign", rm, m_mis);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic load_byte(input logic [7:0] d);
    pw = 1'b1; pd = d; step(); pw = 1'b0;
  endtask

  task automatic fetch(input logic [7:0] a);
    fv = 1'b1; fa = a; step(); fv = 1'b0;
  endtask

  function automatic logic [7:0] fill_byte(input int i);
    case (i)
      0: return 8'h00;
      1: return 8'h70;
      2: return 8'hE0;
      3: return 8'hFF;
      254: return 8'h34;
      255: return 8'h12;
      default: return 8'(i) ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [7:0] d4(input int i);
    return 8'(i * 29) ^ 8'h3C;
  endfunction

  initial begin
    step(); step();
    #1;
    chk("rst resp_valid", rv, 0);
    chk("rst prog_count", pc, 0);
    chk("rst prog_busy", pb, 0);
    chk("rst resp_insn", ri, 0);
    rst = 1'b1;
    step();

    // Four-byte load closed by prog_done.
    ps = 1'b1; step(); ps = 1'b0;
    #1 chk("busy after start", pb, 1);
    load_byte(8'h00); load_byte(8'h70); load_byte(8'hE0); load_byte(8'hFF);
    #1 chk("count after 4", pc, 4);
    pdn = 1'b1; step(); pdn = 1'b0;
    #1 chk("busy after done", pb, 0);

    fetch(8'h02);
    #1;
    chk("fetch02 valid", rv, 1);
    chk("fetch02 insn", ri, 16'hFFE0);
    chk("fetch02 mis", rm, 0);
    fetch(8'h03);
    #1;
    chk("fetch03 insn", ri, 16'hFFE0);
    chk("fetch03 mis", rm, 1);
    step();
    #1 chk("resp drained", rv, 0);

    // Backpressure: first response held while second request waits.
    rr = 1'b0;
    fetch(8'h00);
    fv = 1'b1; fa = 8'h02;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp hold insn", ri, 16'h7000);
      chk("bp ready low", fr, 0);
      step();
    end
    rr = 1'b1;
    step(); fv = 1'b0;
    #1 chk("bp second insn", ri, 16'hFFE0);
    step();
    #1 chk("bp drained", rv, 0);

    // Flush drops a held response; flush with a fetch yields only the new one.
    rr = 1'b0;
    fetch(8'h00);
    fl = 1'b1; step(); fl = 1'b0;
    #1 chk("flush drops", rv, 0);
    fetch(8'h00);
    fl = 1'b1; rr = 1'b1; fv = 1'b1; fa = 8'h02; step();
    fl = 1'b0; fv = 1'b0;
    #1;
    chk("flush+fetch valid", rv, 1);
    chk("flush+fetch insn", ri, 16'hFFE0);
    step();

    // Full 256-byte load ending on the counter wrap.
    ps = 1'b1; step(); ps = 1'b0;
    for (int i = 0; i < 256; i++) load_byte(fill_byte(i));
    #1;
    chk("wrap8 busy", pb, 0);
    chk("wrap8 count", pc, 0);
    fetch(8'hFF);
    #1;
    chk("fetchFF insn", ri, 16'h1234);
    chk("fetchFF mis", rm, 1);
    fetch(8'h10);
    #1 chk("fetch10 insn", ri, {8'h11 ^ 8'hA5, 8'h10 ^ 8'hA5});
    step();

    // Asynchronous reset in the middle of a load.
    ps = 1'b1; pw = 1'b1; pd = 8'hAB; step();
    ps = 1'b0; pd = 8'hCD; step(); pw = 1'b0;
    #1 chk("midload count", pc, 2);
    rst = 1'b0;
    #1;
    chk("arst busy", pb, 0);
    chk("arst valid", rv, 0);
    chk("arst count", pc, 0);
    step();
    rst = 1'b1;
    step();
    fetch(8'h00);
    #1;
    chk("post-rst insn", ri, 16'hCDAB);
    chk("post-rst mis", rm, 0);
    step();

    // Four-bit instance: 16 writes without prog_done wrap the counter.
    p4s = 1'b1; step(); p4s = 1'b0;
    for (int i = 0; i < 16; i++) begin
      p4w = 1'b1; p4d = d4(i); step();
    end
    p4w = 1'b0;
    #1;
    chk("wrap4 busy", p4b, 0);
    chk("wrap4 count", p4c, 0);
    for (int a = 0; a < 15; a++) begin
      int b;
      b = (a / 2) * 2;
      f4v = 1'b1; f4a = 4'(a); step(); f4v = 1'b0;
      #1;
      chk("wrap4 valid", r4v, 1);
      chk("wrap4 insn", r4i, {d4(b + 1), d4(b)});
      chk("wrap4 mis", r4m, a % 2);
    end
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
